// File: rtl/spi_cmd_queue.sv
// ---------------------------------------------------------------------------
// spi_cmd_queue
// Command sequencer placed directly in front of an SPI master. Register
// write/read commands are buffered in a command FIFO and issued one at a time
// on the master's WR/RD/ADDR/DATAI strobe interface, with BUSY used as the
// completion handshake. Read data captured from DATAO is returned through a
// response FIFO, so users see plain valid/ready streams.
//
// Ports
//   clock_i, reset_n_i         clock (rising edge), synchronous active-low reset
//   cmd_valid_i / cmd_ready_o  command stream handshake (ready = FIFO not full)
//   cmd_rw_i                   0 = write, 1 = read
//   cmd_addr_i, cmd_data_i     register address / write data
//   cmd_level_o                command FIFO occupancy
//   rsp_valid_o / rsp_ready_i  response stream handshake
//   rsp_data_o                 head of response FIFO
//   m_wr_o, m_rd_o             one-cycle strobes to the master
//   m_addr_o, m_datai_o        registered address / write data to the master
//   m_datao_i, m_busy_i        read data and busy flag from the master
//   idle_o                     FSM idle and command FIFO empty
//   err_o                      sticky watchdog error
//
// Optional feature: define SPI_CMDQ_TIMEOUT_EN to enable a watchdog that
// aborts a transaction stuck in WAIT_ACK/WAIT_DONE for TIMEOUT cycles. With
// the macro undefined the FSM waits indefinitely and err_o is tied low.
//
// State table
//   S_IDLE      | waiting for a command the master can accept
//   S_ISSUE     | strobe (m_wr_o or m_rd_o) high for this one cycle
//   S_WAIT_ACK  | waiting for the master to raise BUSY
//   S_WAIT_DONE | waiting for BUSY to fall; reads push DATAO here
// ---------------------------------------------------------------------------
module spi_cmd_queue #(
    parameter int D          = 8,
    parameter int A          = 4,
    parameter int DEPTH_LOG2 = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clock_i,
    input  logic                  reset_n_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_rw_i,
    input  logic [A-1:0]          cmd_addr_i,
    input  logic [D-1:0]          cmd_data_i,
    output logic [DEPTH_LOG2:0]   cmd_level_o,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [D-1:0]          rsp_data_o,
    output logic                  m_wr_o,
    output logic                  m_rd_o,
    output logic [A-1:0]          m_addr_o,
    output logic [D-1:0]          m_datai_o,
    input  logic [D-1:0]          m_datao_i,
    input  logic                  m_busy_i,
    output logic                  idle_o,
    output logic                  err_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE
    } state_t;

    state_t state_q, state_d;

    // ------------------------------------------------------------------
    // Command FIFO: entries are {rw, addr, data}
    // ------------------------------------------------------------------
    logic [A+D:0]          cmd_mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] cmd_wptr_q, cmd_rptr_q;
    logic [CW-1:0]         cmd_cnt_q;
    logic                  cmd_push, cmd_pop, cmd_full, cmd_empty;
    logic                  head_rw;
    logic [A-1:0]          head_addr;
    logic [D-1:0]          head_data;

    assign cmd_full    = (cmd_cnt_q == CW'(DEPTH));
    assign cmd_empty   = (cmd_cnt_q == '0);
    // Ready depends only on fullness, so a same-cycle pop never frees a slot.
    assign cmd_ready_o = !cmd_full;
    assign cmd_push    = cmd_valid_i && !cmd_full;
    assign cmd_level_o = cmd_cnt_q;
    assign {head_rw, head_addr, head_data} = cmd_mem_q[cmd_rptr_q];

    always_ff @(posedge clock_i) begin
        if (cmd_push) begin
            cmd_mem_q[cmd_wptr_q] <= {cmd_rw_i, cmd_addr_i, cmd_data_i};
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            cmd_wptr_q <= '0;
            cmd_rptr_q <= '0;
            cmd_cnt_q  <= '0;
        end else begin
            if (cmd_push) cmd_wptr_q <= cmd_wptr_q + 1'b1;
            if (cmd_pop)  cmd_rptr_q <= cmd_rptr_q + 1'b1;
            cmd_cnt_q <= cmd_cnt_q + CW'(cmd_push) - CW'(cmd_pop);
        end
    end

    // ------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------
    logic [D-1:0]          rsp_mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] rsp_wptr_q, rsp_rptr_q;
    logic [CW-1:0]         rsp_cnt_q;
    logic                  rsp_push, rsp_pop, rsp_full;
    logic [D-1:0]          rsp_wdata;

    assign rsp_full    = (rsp_cnt_q == CW'(DEPTH));
    assign rsp_valid_o = (rsp_cnt_q != '0);
    assign rsp_pop     = rsp_valid_o && rsp_ready_i;
    assign rsp_data_o  = rsp_mem_q[rsp_rptr_q];

    always_ff @(posedge clock_i) begin
        if (rsp_push) begin
            rsp_mem_q[rsp_wptr_q] <= rsp_wdata;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            rsp_wptr_q <= '0;
            rsp_rptr_q <= '0;
            rsp_cnt_q  <= '0;
        end else begin
            if (rsp_push) rsp_wptr_q <= rsp_wptr_q + 1'b1;
            if (rsp_pop)  rsp_rptr_q <= rsp_rptr_q + 1'b1;
            rsp_cnt_q <= rsp_cnt_q + CW'(rsp_push) - CW'(rsp_pop);
        end
    end

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    logic tmo;

`ifdef SPI_CMDQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt_q;
    logic          err_q;
    logic          err_set;

    // Cleared while in ISSUE, which is the only way into WAIT_ACK; the FSM
    // leaves the wait states on the terminal count, so no saturation needed.
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            tmo_cnt_q <= '0;
        end else if (state_q == S_ISSUE) begin
            tmo_cnt_q <= '0;
        end else if (state_q == S_WAIT_ACK || state_q == S_WAIT_DONE) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    // Fires on the TIMEOUT-th cycle spent in the wait states.
    assign tmo = (tmo_cnt_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    // Watchdog absent: never fires (compare keeps TIMEOUT referenced).
    assign tmo   = (TIMEOUT < 0);
    assign err_o = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    logic         cur_rw_q;
    logic         m_wr_q, m_rd_q;
    logic [A-1:0] m_addr_q;
    logic [D-1:0] m_datai_q;
    logic         abort;

    always_comb begin
        state_d   = state_q;
        cmd_pop   = 1'b0;
        rsp_push  = 1'b0;
        rsp_wdata = m_datao_i;
        abort     = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A read at the head waits for a response slot: strict order.
                if (!cmd_empty && !m_busy_i && (!head_rw || !rsp_full)) begin
                    cmd_pop = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (tmo) begin
                    abort = 1'b1;
                end else if (m_busy_i) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                // Normal completion wins over a same-cycle timeout.
                if (!m_busy_i) begin
                    rsp_push = cur_rw_q;
                    state_d  = S_IDLE;
                end else if (tmo) begin
                    abort = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // An aborted read still returns a (zero) response so the consumer
        // stays aligned with the command stream.
        if (abort) begin
            rsp_push  = cur_rw_q;
            rsp_wdata = '0;
            state_d   = S_IDLE;
        end
    end

`ifdef SPI_CMDQ_TIMEOUT_EN
    assign err_set = abort;
`endif

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state_q   <= S_IDLE;
            cur_rw_q  <= 1'b0;
            m_wr_q    <= 1'b0;
            m_rd_q    <= 1'b0;
            m_addr_q  <= '0;
            m_datai_q <= '0;
        end else begin
            state_q <= state_d;
            // Strobes are registered from the pop, so they are high exactly
            // during S_ISSUE.
            m_wr_q  <= cmd_pop && !head_rw;
            m_rd_q  <= cmd_pop && head_rw;
            if (cmd_pop) begin
                cur_rw_q  <= head_rw;
                m_addr_q  <= head_addr;
                m_datai_q <= head_data;
            end
        end
    end

    assign m_wr_o    = m_wr_q;
    assign m_rd_o    = m_rd_q;
    assign m_addr_o  = m_addr_q;
    assign m_datai_o = m_datai_q;
    assign idle_o    = (state_q == S_IDLE) && cmd_empty;

endmodule

// File: tb/tb_spi_cmd_queue.sv
module tb_spi_cmd_queue;

    localparam int D     = 8;
    localparam int A     = 4;
    localparam int DL    = 2;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic          clock_i = 1'b0;
    logic          reset_n_i;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic          cmd_rw_i;
    logic [A-1:0]  cmd_addr_i;
    logic [D-1:0]  cmd_data_i;
    logic [DL:0]   cmd_level_o;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [D-1:0]  rsp_data_o;
    logic          m_wr_o;
    logic          m_rd_o;
    logic [A-1:0]  m_addr_o;
    logic [D-1:0]  m_datai_o;
    logic [D-1:0]  m_datao_i;
    logic          m_busy_i;
    logic          idle_o;
    logic          err_o;

    always #5 clock_i = ~clock_i;

    spi_cmd_queue #(.D(D), .A(A), .DEPTH_LOG2(DL), .TIMEOUT(TMO)) dut (
        .clock_i     (clock_i),
        .reset_n_i   (reset_n_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_rw_i    (cmd_rw_i),
        .cmd_addr_i  (cmd_addr_i),
        .cmd_data_i  (cmd_data_i),
        .cmd_level_o (cmd_level_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .m_wr_o      (m_wr_o),
        .m_rd_o      (m_rd_o),
        .m_addr_o    (m_addr_o),
        .m_datai_o   (m_datai_o),
        .m_datao_i   (m_datao_i),
        .m_busy_i    (m_busy_i),
        .idle_o      (idle_o),
        .err_o       (err_o)
    );

    typedef struct packed {
        logic         rw;
        logic [A-1:0] addr;
        logic [D-1:0] data;
    } cmd_t;

    // Reference model: commands accepted but not yet issued, responses owed.
    cmd_t         cmd_q[$];
    logic [D-1:0] rsp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    bit           inflight    = 0;
    bit           rsp_pend    = 0;
    bit           pend_is_rd  = 0;
    logic [D-1:0] pend_data   = '0;
    bit           popped_last = 0;
    bit           err_exp     = 0;
    int           strobes     = 0;
    logic [A-1:0] hold_addr   = '0;
    logic [D-1:0] hold_data   = '0;
    bit           hold_dchk   = 0;

    bit           auto_slave  = 0;
    bit           sl_active   = 0;
    bit           sl_rd       = 0;
    int           sl_pre      = 0;
    int           sl_hold     = 0;
    bit           busy_dir    = 0;
    bit           fix_en      = 0;
    logic [D-1:0] fix_rdata   = '0;

    bit           host_rand   = 0;
    bit           rsp_rdy_dir = 0;
    int           cmd_pct     = 50;
    int           rsp_pct     = 50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: observe at the falling edge, update the model, then drive
    // the inputs for the next rising edge.
    task automatic step();
        cmd_t         cur;
        cmd_t         nc;
        logic [D-1:0] rd;
        @(negedge clock_i);

        if (rsp_pend) begin
            rsp_pend = 0;
            inflight = 0;
            if (pend_is_rd) rsp_q.push_back(pend_data);
        end

        if (m_wr_o || m_rd_o) begin
            chk("strobe_excl", m_wr_o & m_rd_o, 1'b0);
            chk("strobe_once", inflight, 1'b0);
            chk("issue_busy_low", m_busy_i, 1'b0);
            chk("issue_has_cmd", cmd_q.size() != 0, 1'b1);
            if (cmd_q.size() != 0) begin
                cur = cmd_q.pop_front();
                chk("issue_rw", m_rd_o, cur.rw);
                chk("issue_addr", m_addr_o, cur.addr);
                if (!cur.rw) chk("issue_datai", m_datai_o, cur.data);
                else chk("issue_rsp_slot", (rsp_q.size() + popped_last) < DEPTH, 1'b1);
                hold_addr = cur.addr;
                hold_data = cur.data;
                hold_dchk = !cur.rw;
                sl_rd     = cur.rw;
            end
            inflight = 1;
            strobes++;
            if (auto_slave) begin
                sl_active = 1;
                sl_pre    = $urandom_range(0, 2);
                sl_hold   = $urandom_range(2, 4);
            end
        end else if (inflight) begin
            chk("addr_hold", m_addr_o, hold_addr);
            if (hold_dchk) chk("datai_hold", m_datai_o, hold_data);
        end

        chk("cmd_level", cmd_level_o, cmd_q.size());
        chk("cmd_ready", cmd_ready_o, cmd_q.size() < DEPTH);
        chk("rsp_valid", rsp_valid_o, rsp_q.size() != 0);
        if (rsp_q.size() != 0) chk("rsp_data", rsp_data_o, rsp_q[0]);
        chk("idle", idle_o, !inflight && cmd_q.size() == 0);
        chk("err", err_o, err_exp);

        // Slave model: optional ack delay, BUSY for 2..4 cycles, data on the fall.
        m_datao_i = D'($urandom);
        if (auto_slave) begin
            if (!sl_active) begin
                m_busy_i = 1'b0;
            end else if (sl_pre > 0) begin
                sl_pre--;
                m_busy_i = 1'b0;
            end else if (sl_hold > 0) begin
                sl_hold--;
                m_busy_i = 1'b1;
            end else begin
                rd         = fix_en ? fix_rdata : D'($urandom);
                m_busy_i   = 1'b0;
                m_datao_i  = rd;
                sl_active  = 0;
                rsp_pend   = 1;
                pend_is_rd = sl_rd;
                pend_data  = rd;
            end
        end else begin
            m_busy_i = busy_dir;
        end

        popped_last = 0;
        if (host_rand) begin
            cmd_valid_i = ($urandom_range(0, 99) < cmd_pct);
            cmd_rw_i    = 1'($urandom_range(0, 1));
            cmd_addr_i  = A'($urandom);
            cmd_data_i  = D'($urandom);
            rsp_ready_i = ($urandom_range(0, 99) < rsp_pct);
            if (cmd_valid_i && cmd_q.size() < DEPTH) begin
                nc.rw = cmd_rw_i; nc.addr = cmd_addr_i; nc.data = cmd_data_i;
                cmd_q.push_back(nc);
            end
        end else begin
            cmd_valid_i = 1'b0;
            rsp_ready_i = rsp_rdy_dir;
        end
        if (rsp_ready_i && rsp_q.size() != 0) begin
            void'(rsp_q.pop_front());
            popped_last = 1;
        end
    endtask

    task automatic send(input logic rw, input logic [A-1:0] addr, input logic [D-1:0] data);
        cmd_t nc;
        cmd_valid_i = 1'b1;
        cmd_rw_i    = rw;
        cmd_addr_i  = addr;
        cmd_data_i  = data;
        if (cmd_q.size() < DEPTH) begin
            nc.rw = rw; nc.addr = addr; nc.data = data;
            cmd_q.push_back(nc);
        end
        step();
    endtask

    task automatic wait_strobes(input int target, input int bound);
        for (int i = 0; i < bound && strobes < target; i++) step();
        chk("strobe_count", strobes, target);
    endtask

    task automatic drain(input int bound, input bit want_rsp_empty);
        for (int i = 0; i < bound &&
             !(cmd_q.size() == 0 && !inflight && (!want_rsp_empty || rsp_q.size() == 0)); i++)
            step();
        chk("drain_done", cmd_q.size() == 0 && !inflight && (!want_rsp_empty || rsp_q.size() == 0), 1'b1);
    endtask

    task automatic do_reset();
        reset_n_i = 1'b0;
        cmd_q.delete();
        rsp_q.delete();
        inflight = 0; rsp_pend = 0; sl_active = 0; popped_last = 0; err_exp = 0;
        step();
        chk("rst_m_wr", m_wr_o, 1'b0);
        chk("rst_m_rd", m_rd_o, 1'b0);
        chk("rst_m_addr", m_addr_o, '0);
        chk("rst_m_datai", m_datai_o, '0);
        reset_n_i = 1'b1;
    endtask

    int s0;
    int s1;
    int cmd_pct_tab[4] = '{70, 30, 90, 50};
    int rsp_pct_tab[4] = '{80, 20, 10, 95};

    initial begin
        reset_n_i   = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_rw_i    = 1'b0;
        cmd_addr_i  = '0;
        cmd_data_i  = '0;
        rsp_ready_i = 1'b0;
        m_datao_i   = '0;
        m_busy_i    = 1'b0;

        // Reset state
        repeat (2) step();
        do_reset();
        step();

        // Single write: addr 7, data 205; strobe one edge after the push
        auto_slave = 1;
        s0 = strobes;
        send(1'b0, 4'd7, 8'd205);
        chk("t1_not_yet", strobes, s0);
        step();
        chk("t1_latency", strobes, s0 + 1);
        drain(20, 0);
        chk("t1_no_rsp", rsp_valid_o, 1'b0);
        chk("t1_idle", idle_o, 1'b1);

        // Single read: slave returns 0xCD
        fix_en = 1; fix_rdata = 8'hCD;
        send(1'b1, 4'd7, 8'h11);
        drain(20, 0);
        chk("t2_rsp_valid", rsp_valid_o, 1'b1);
        chk("t2_rsp_data", rsp_data_o, 8'hCD);
        rsp_rdy_dir = 1;
        step();
        rsp_rdy_dir = 0;
        step();
        chk("t2_popped", rsp_valid_o, 1'b0);
        fix_en = 0;

        // Full command FIFO while BUSY is held high
        auto_slave = 0; busy_dir = 1;
        step();
        s0 = strobes;
        for (int i = 0; i < 5; i++) send(1'(i % 2), A'(i + 1), D'(8'h20 + i));
        chk("t3_level", cmd_level_o, 4);
        chk("t3_ready", cmd_ready_o, 1'b0);
        chk("t3_no_issue", strobes, s0);
        auto_slave = 1; rsp_rdy_dir = 1;
        drain(200, 1);
        chk("t3_issued", strobes, s0 + 4);

        // Full response FIFO stalls the fifth read
        rsp_rdy_dir = 0;
        s0 = strobes;
        for (int i = 0; i < 5; i++) send(1'b1, A'(8 + i), 8'h00);
        wait_strobes(s0 + 4, 200);
        repeat (20) step();
        chk("t4_stalled", strobes, s0 + 4);
        chk("t4_level", cmd_level_o, 1);
        chk("t4_rsp_valid", rsp_valid_o, 1'b1);
        rsp_rdy_dir = 1;
        step();
        rsp_rdy_dir = 0;
        wait_strobes(s0 + 5, 20);
        rsp_rdy_dir = 1;
        drain(200, 1);

        // Reset in WAIT_DONE with BUSY high
        auto_slave = 0; busy_dir = 0;
        s0 = strobes;
        send(1'b1, 4'd5, 8'h00);
        wait_strobes(s0 + 1, 5);
        busy_dir = 1;
        repeat (3) step();
        chk("t5_busy_phase", idle_o, 1'b0);
        do_reset();
        chk("t5_rst_level", cmd_level_o, 0);
        chk("t5_rst_rsp", rsp_valid_o, 1'b0);
        s0 = strobes;
        send(1'b0, 4'd9, 8'h5A);
        repeat (6) step();
        chk("t5_hold_off", strobes, s0);
        busy_dir = 0; auto_slave = 1;
        wait_strobes(s0 + 1, 10);
        drain(50, 1);

        // BUSY stuck high on a read
        auto_slave = 0; busy_dir = 0;
        s0 = strobes;
        send(1'b1, 4'd3, 8'h00);
        wait_strobes(s0 + 1, 5);
        busy_dir = 1;
`ifdef SPI_CMDQ_TIMEOUT_EN
        for (int k = 1; k <= TMO; k++) step();
        chk("t6_err_pre", err_o, 1'b0);
        err_exp = 1; rsp_pend = 1; pend_is_rd = 1; pend_data = '0;
        step();
        chk("t6_err", err_o, 1'b1);
        chk("t6_rsp_zero", rsp_data_o, 8'h00);
        s1 = strobes;
        send(1'b0, 4'd4, 8'h3C);
        repeat (5) step();
        chk("t6_wait_busy", strobes, s1);
        busy_dir = 0; auto_slave = 1; rsp_rdy_dir = 1;
        wait_strobes(s1 + 1, 10);
        drain(50, 1);
        chk("t6_err_sticky", err_o, 1'b1);
`else
        repeat (40) step();
        chk("t6_stuck_err", err_o, 1'b0);
        chk("t6_stuck_idle", idle_o, 1'b0);
        chk("t6_stuck_rsp", rsp_valid_o, 1'b0);
        s1 = strobes;
        chk("t6_stuck_count", s1, s0 + 1);
`endif
        do_reset();
        busy_dir = 0;
        step();

        // Randomized traffic against the model
        auto_slave = 1; host_rand = 1;
        for (int r = 0; r < 4; r++) begin
            cmd_pct = cmd_pct_tab[r];
            rsp_pct = rsp_pct_tab[r];
            repeat (500) step();
        end
        host_rand = 0; rsp_rdy_dir = 1;
        drain(500, 1);
        chk("final_idle", idle_o, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
